mem_arbiter: RTL and testbench

- Shares the single DMA/CPU/accelerator port of memory_controller among three requesters: DMA (index 0), CPU (index 1) and accelerator (index 2).
- Accepts one request at a time, latches its payload, and drives a single-cycle enable to memory_controller.
- Waits for memory_controller's valid strobe, then returns read data, completion and error back to the winning requester.
- Default policy is round-robin; a per-transaction timeout guarantees forward progress.

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory_controller command port among DMA (0),
// CPU (1) and accelerator (2). One transaction in flight at a time:
// IDLE arbitrates, ISSUE pulses the command, WAIT collects the response
// or times out. Optional macro MEM_ARB_DMA_PRIO_EN gives DMA absolute
// priority with CPU/ACL round-robin between themselves.
module mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 28,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                req,
  input  logic [2:0]                req_wr,
  input  logic [3*ADDR_WIDTH-1:0]   req_addr,
  input  logic [3*DATA_WIDTH-1:0]   req_wdata,
  output logic [2:0]                gnt,
  output logic [2:0]                done,
  output logic [2:0]                err,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [1:0]              last_r;
  logic [1:0]              win_r;
  logic [TW-1:0]           timer_r;

  logic                    win_valid_s;
  logic [1:0]              win_idx_s;
  logic                    wr_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [DATA_WIDTH-1:0]   wdata_s;

  // Requester index to one-hot grant/done vector.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] v;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Pick the winner among pending requests, starting after the last grant.
  always_comb begin
    win_valid_s = 1'b1;
    win_idx_s   = 2'd0;
`ifdef MEM_ARB_DMA_PRIO_EN
    if (req[0]) begin
      win_idx_s = 2'd0;
    end else if (last_r == 2'd1) begin
      if (req[2]) begin
        win_idx_s = 2'd2;
      end else if (req[1]) begin
        win_idx_s = 2'd1;
      end else begin
        win_valid_s = 1'b0;
      end
    end else begin
      if (req[1]) begin
        win_idx_s = 2'd1;
      end else if (req[2]) begin
        win_idx_s = 2'd2;
      end else begin
        win_valid_s = 1'b0;
      end
    end
`else
    case (last_r)
      2'd0: begin
        if (req[1])      win_idx_s = 2'd1;
        else if (req[2]) win_idx_s = 2'd2;
        else if (req[0]) win_idx_s = 2'd0;
        else             win_valid_s = 1'b0;
      end
      2'd1: begin
        if (req[2])      win_idx_s = 2'd2;
        else if (req[0]) win_idx_s = 2'd0;
        else if (req[1]) win_idx_s = 2'd1;
        else             win_valid_s = 1'b0;
      end
      default: begin
        if (req[0])      win_idx_s = 2'd0;
        else if (req[1]) win_idx_s = 2'd1;
        else if (req[2]) win_idx_s = 2'd2;
        else             win_valid_s = 1'b0;
      end
    endcase
`endif
  end

  // Select the winning requester's payload slice.
  always_comb begin
    wr_s    = 1'b0;
    addr_s  = '0;
    wdata_s = '0;
    case (win_idx_s)
      2'd0: begin
        wr_s    = req_wr[0];
        addr_s  = req_addr[0 +: ADDR_WIDTH];
        wdata_s = req_wdata[0 +: DATA_WIDTH];
      end
      2'd1: begin
        wr_s    = req_wr[1];
        addr_s  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
        wdata_s = req_wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        wr_s    = req_wr[2];
        addr_s  = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_s = req_wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
    endcase
  end

  // Transaction FSM; all outputs are registered and pulses default low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      last_r    <= 2'd2;
      win_r     <= 2'd0;
      timer_r   <= '0;
      gnt       <= 3'b000;
      done      <= 3'b000;
      err       <= 3'b000;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt    <= 3'b000;
      done   <= 3'b000;
      err    <= 3'b000;
      rdata  <= '0;
      mem_en <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s) begin
            win_r     <= win_idx_s;
            mem_wr_en <= wr_s;
            mem_addr  <= addr_s;
            mem_wdata <= wdata_s;
            gnt       <= onehot3(win_idx_s);
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ST_ISSUE;
`ifdef MEM_ARB_DMA_PRIO_EN
            // DMA grants leave the CPU/ACL rotation untouched.
            if (win_idx_s != 2'd0) begin
              last_r <= win_idx_s;
            end
`else
            last_r <= win_idx_s;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ISSUE: begin
          timer_r <= '0;
          busy    <= 1'b1;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_valid) begin
            // A response in the last WAIT cycle beats the timeout.
            done    <= onehot3(win_r);
            rdata   <= mem_wr_en ? '0 : mem_rdata;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (timer_r == T_LAST) begin
            done    <= onehot3(win_r);
            err     <= onehot3(win_r);
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            timer_r <= timer_r + T_ONE;
            busy    <= 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions,
// then hand sequences for timeout with a pending request, reset in WAIT
// and round-robin ordering. Honours MEM_ARB_DMA_PRIO_EN if defined.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 28;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req;
  logic [2:0]      req_wr;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      gnt, done, err;
  logic [DW-1:0]   rdata;
  logic            busy, mem_en, mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .busy(busy), .mem_en(mem_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]    req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;     // cycles after mem_en to mem_valid; 0 = never
    logic [DW-1:0] mrdata;
    logic [2:0]    e_gnt;
    logic [2:0]    e_err;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int ok);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt != 3'b000) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) check("gnt_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic run_txn(input int id, input vec_t v);
    int idx;
    int ok;
    int dk;
    int exp_dk;
    idx = (v.e_gnt == 3'b001) ? 0 : (v.e_gnt == 3'b010) ? 1 : 2;
    for (int i = 0; i < 3; i++) begin
      req_wr[i]             = (i == idx) ? v.wr : ~v.wr;
      req_addr[i*AW +: AW]  = (i == idx) ? v.addr : ~v.addr;
      req_wdata[i*DW +: DW] = (i == idx) ? v.wdata : ~v.wdata;
    end
    req       = v.req;
    mem_rdata = v.mrdata;
    wait_gnt(ok);
    check($sformatf("v%0d_gnt", id), {61'd0, gnt}, {61'd0, v.e_gnt});
    check($sformatf("v%0d_mem_en", id), {63'd0, mem_en}, 64'd1);
    check($sformatf("v%0d_mem_wr_en", id), {63'd0, mem_wr_en}, {63'd0, v.wr});
    check($sformatf("v%0d_mem_addr", id), {36'd0, mem_addr}, {36'd0, v.addr});
    check($sformatf("v%0d_mem_wdata", id), {32'd0, mem_wdata}, {32'd0, v.wdata});
    req = 3'b000;
    dk = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done != 3'b000) begin
        dk = k;
        break;
      end
      if (k == 1) begin
        check($sformatf("v%0d_wait_hold", id), {mem_en, busy, mem_addr}, {1'b0, 1'b1, v.addr});
      end
      mem_valid = (k == v.lat);
    end
    mem_valid = 1'b0;
    exp_dk = (v.lat == 0) ? TO + 1 : v.lat + 1;
    check($sformatf("v%0d_done_cycle", id), 64'(dk), 64'(exp_dk));
    check($sformatf("v%0d_done", id), {61'd0, done}, {61'd0, v.e_gnt});
    check($sformatf("v%0d_err", id), {61'd0, err}, {61'd0, v.e_err});
    check($sformatf("v%0d_rdata", id), {32'd0, rdata}, {32'd0, v.e_rdata});
    @(negedge clk);
    check($sformatf("v%0d_after", id), {58'd0, done, busy, gnt[1:0]}, 64'd0);
  endtask

  logic [2:0] rr_exp [5];

  initial begin
    int ok;
    int dk;
    int prev;

    vecs[0] = '{3'b010, 1'b0, 28'h10,      32'h0,        3, 32'hDEADBEEF, 3'b010, 3'b000, 32'hDEADBEEF};
    vecs[1] = '{3'b100, 1'b1, 28'h20,      32'h12345678, 2, 32'hFFFF0000, 3'b100, 3'b000, 32'h0};
    vecs[2] = '{3'b011, 1'b0, 28'h300,     32'h0,        1, 32'h11111111, 3'b001, 3'b000, 32'h11111111};
    vecs[3] = '{3'b110, 1'b0, 28'hABCDEF0, 32'h0,        1, 32'h22222222, 3'b010, 3'b000, 32'h22222222};
    vecs[4] = '{3'b110, 1'b1, 28'h44,      32'h0BADF00D, 4, 32'h33333333, 3'b100, 3'b000, 32'h0};
    vecs[5] = '{3'b111, 1'b1, 28'h55,      32'h5555AAAA, 1, 32'h0,        3'b001, 3'b000, 32'h0};
    vecs[6] = '{3'b110, 1'b0, 28'h66,      32'h0,        5, 32'h66666666, 3'b010, 3'b000, 32'h66666666};
    vecs[7] = '{3'b001, 1'b0, 28'h77,      32'h0,        0, 32'h77777777, 3'b001, 3'b001, 32'h0};
    vecs[8] = '{3'b100, 1'b0, 28'h88,      32'h0,        TO, 32'hA5A5A5A5, 3'b100, 3'b000, 32'hA5A5A5A5};
    vecs[9] = '{3'b101, 1'b1, 28'h99,      32'h99999999, 1, 32'h0,        3'b001, 3'b000, 32'h0};

    rst_n = 1'b0; req = 3'b000; req_wr = 3'b000; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {58'd0, gnt, done}, 64'd0);
    check("reset_misc", {err, busy, mem_en, mem_wr_en, mem_addr, rdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", {58'd0, gnt, mem_en, busy, done[0]}, 64'd0);

    for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

    // Timeout with ACL pending: ACL must be granted straight after done.
    req_wr = 3'b000; req_addr = '0; req_wdata = '0; mem_rdata = 32'h55;
    req = 3'b110;
    wait_gnt(ok);
    check("tp_gnt_cpu", {61'd0, gnt}, 64'd2);
    req = 3'b100;
    dk = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done != 3'b000) begin
        dk = k;
        break;
      end
    end
    check("tp_done_cycle", 64'(dk), 64'(TO + 1));
    check("tp_done_err", {58'd0, done, err}, {58'd0, 3'b010, 3'b010});
    @(negedge clk);
    check("tp_next_gnt", {60'd0, gnt, mem_en}, {60'd0, 3'b100, 1'b1});
    req = 3'b000;
    @(negedge clk);
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    check("tp_acl_done", {29'd0, done, rdata}, {29'd0, 3'b100, 32'h55});

    // Reset in WAIT aborts the transaction.
    req_wr = 3'b010; req_addr = {28'd0, 28'h0ABC, 28'd0}; req_wdata = {32'd0, 32'hCAFEF00D, 32'd0};
    req = 3'b010;
    wait_gnt(ok);
    req = 3'b000;
    repeat (2) @(negedge clk);
    check("rw_pre_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rw_rst_ctrl", {52'd0, gnt, done, err, busy, mem_en, mem_wr_en}, 64'd0);
    check("rw_rst_addr", {36'd0, mem_addr}, 64'd0);
    check("rw_rst_data", {mem_wdata, rdata}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("rw_no_done", {61'd0, done}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 32'h12121212;
    @(negedge clk);
    mem_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rw_stray_ignored", {54'd0, done, busy, gnt, mem_en, rdata[2:0]}, 64'd0);
    end

    // Round-robin with all requests held and a 1-cycle memory.
`ifdef MEM_ARB_DMA_PRIO_EN
    rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
`endif
    req_wr = 3'b000; mem_rdata = 32'h0;
    req = 3'b111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(ok);
      check($sformatf("rr_gnt%0d", g), {61'd0, gnt}, {61'd0, rr_exp[g]});
      if (g > 0) check($sformatf("rr_spacing%0d", g), 64'(cyc - prev), 64'd3);
      prev = cyc;
      @(negedge clk);
      mem_valid = 1'b1;
      @(negedge clk);
      mem_valid = 1'b0;
      check($sformatf("rr_done%0d", g), {61'd0, done}, {61'd0, rr_exp[g]});
    end
`ifdef MEM_ARB_DMA_PRIO_EN
    // DMA drops out: CPU and ACL alternate from the untouched pointer.
    rr_exp = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
    req = 3'b110;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(ok);
      check($sformatf("prio_gnt%0d", g), {61'd0, gnt}, {61'd0, rr_exp[g]});
      @(negedge clk);
      mem_valid = 1'b1;
      @(negedge clk);
      mem_valid = 1'b0;
    end
`endif
    req = 3'b000;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
